// File: rtl/bist_ctrl_misr.sv
// BIST controller: an LFSR drives patterns into an external combinational CUT,
// and a MISR compacts the responses into a signature checked against a golden value.
module bist_ctrl_misr #(
    parameter int                   PAT_W     = 5,
    parameter logic [PAT_W-1:0]     PAT_POLY  = 5'b10100,
    parameter logic [PAT_W-1:0]     SEED      = 5'b00001,
    parameter int                   NUM_PAT   = 31,
    parameter int                   RSP_W     = 4,
    parameter logic [RSP_W-1:0]     MISR_POLY = 4'b1001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [PAT_W-1:0] pat,
    output logic             pat_valid,
    input  logic [RSP_W-1:0] rsp,
    input  logic [RSP_W-1:0] exp_sig,
    output logic [RSP_W-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int CNT_W = $clog2(NUM_PAT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [PAT_W-1:0] lfsr_next;
    logic [RSP_W-1:0] misr_next;

    // The MISR absorbs the response to the pattern currently on pat, so the
    // signature after the last RUN edge covers every applied pattern.
    always_comb begin
        lfsr_next = {pat[PAT_W-2:0], ^(pat & PAT_POLY)};
        misr_next = {sig[RSP_W-2:0], ^(sig & MISR_POLY)} ^ rsp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pat   <= SEED;
            sig   <= '0;
            cnt   <= '0;
            pass  <= 1'b0;
        end else if (abort) begin
            // pat and sig are left untouched so the aborted point can be inspected
            state <= IDLE;
            cnt   <= '0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        pat   <= SEED;
                        sig   <= '0;
                        cnt   <= '0;
                        pass  <= 1'b0;
                    end
                end
                RUN: begin
                    sig <= misr_next;
                    pat <= lfsr_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                        pass  <= (misr_next == exp_sig);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign pat_valid = (state == RUN);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_bist_ctrl_misr.sv
// Bench for bist_ctrl_misr: a default-parameter instance driven by a behavioural CUT
// and signature model, plus a NUM_PAT=1 instance for the single-pattern corner.
module tb_bist_ctrl_misr;

    localparam int              NUM_PAT   = 31;
    localparam logic [4:0]      SEED      = 5'b00001;
    localparam logic [4:0]      PAT_POLY  = 5'b10100;
    localparam logic [3:0]      MISR_POLY = 4'b1001;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort;
    logic [4:0] pat;
    logic       pat_valid;
    logic [3:0] rsp, exp_sig, sig;
    logic       busy, done, pass;

    logic       start2, abort2;
    logic [4:0] pat2;
    logic       pat_valid2;
    logic [3:0] rsp2, exp2, sig2;
    logic       busy2, done2, pass2;

    int         vectors = 0;
    int         miscompares = 0;

    int         rsp_mode;
    logic       fault;
    logic [3:0] lut [32];

    bist_ctrl_misr dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pat(pat), .pat_valid(pat_valid), .rsp(rsp), .exp_sig(exp_sig),
        .sig(sig), .busy(busy), .done(done), .pass(pass)
    );

    bist_ctrl_misr #(.NUM_PAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .pat(pat2), .pat_valid(pat_valid2), .rsp(rsp2), .exp_sig(exp2),
        .sig(sig2), .busy(busy2), .done(done2), .pass(pass2)
    );

    always #5 clk = ~clk;

    // Behavioural CUT; the fault sticks the all-ones detector at 0, which only
    // matters for pattern 1F, so the signature difference is a single injected error.
    function automatic logic [3:0] cut(input logic [4:0] p, input logic f);
        logic [3:0] r;
        r[3] = p[4] ^ p[0];
        r[2] = p[3] & p[1];
        r[1] = p[2] | p[0];
        r[0] = (&p) & ~f;
        return r;
    endfunction

    function automatic logic [3:0] resp_of(input logic [4:0] p);
        if (rsp_mode == 0)      return 4'h0;
        else if (rsp_mode == 1) return cut(p, fault);
        else                    return lut[p];
    endfunction

    always_comb rsp = resp_of(pat);

    function automatic logic [4:0] m_lfsr(input logic [4:0] q);
        int v;
        v = int'(q);
        return 5'(((v * 2) % 32) + ($countones(q & PAT_POLY) % 2));
    endfunction

    function automatic logic [3:0] m_misr(input logic [3:0] m, input logic [3:0] r);
        int v;
        v = int'(m);
        return 4'(((v * 2) % 16) + ($countones(m & MISR_POLY) % 2)) ^ r;
    endfunction

    function automatic logic [4:0] model_pat(input int n);
        logic [4:0] q;
        q = SEED;
        for (int i = 0; i < n; i++) q = m_lfsr(q);
        return q;
    endfunction

    function automatic logic [3:0] model_sig(input int n);
        logic [4:0] q;
        logic [3:0] m;
        q = SEED;
        m = 4'h0;
        for (int i = 0; i < n; i++) begin
            m = m_misr(m, resp_of(q));
            q = m_lfsr(q);
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic a);
        start = s;
        abort = a;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start a run and wait (bounded) for it to leave RUN; the run length is checked.
    task automatic applyRun(input logic hold_start);
        int n;
        n = 0;
        applyStimulus(1'b1, 1'b0);
        while (busy && n < 100) begin
            n++;
            applyStimulus(hold_start, 1'b0);
        end
        checkOutput("run_len", n, NUM_PAT);
    endtask

    typedef struct {
        logic       start;
        logic       busy;
        logic       done;
        logic [4:0] pat;
        logic [3:0] sig;
    } vec_t;

    vec_t       tbl [6];
    bit         seen [32];
    int         nbusy, nvalid, ndistinct, abort_at;
    logic [3:0] golden, faulty, exp_pass;
    logic [4:0] q;

    initial begin
        tbl[0] = '{start: 1'b0, busy: 1'b0, done: 1'b0, pat: 5'h01, sig: 4'h0};
        tbl[1] = '{start: 1'b1, busy: 1'b1, done: 1'b0, pat: 5'h01, sig: 4'h0};
        tbl[2] = '{start: 1'b0, busy: 1'b1, done: 1'b0, pat: 5'h02, sig: 4'h0};
        tbl[3] = '{start: 1'b1, busy: 1'b1, done: 1'b0, pat: 5'h04, sig: 4'h0};
        tbl[4] = '{start: 1'b0, busy: 1'b1, done: 1'b0, pat: 5'h09, sig: 4'h0};
        tbl[5] = '{start: 1'b0, busy: 1'b1, done: 1'b0, pat: 5'h12, sig: 4'h0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; exp_sig = 4'h0;
        start2 = 1'b0; abort2 = 1'b0; rsp2 = 4'h0; exp2 = 4'h0;
        rsp_mode = 0; fault = 1'b0;
        for (int i = 0; i < 32; i++) lut[i] = 4'h0;
        repeat (2) tick();
        checkOutput("rst_pat", pat, 5'h01);
        checkOutput("rst_sig", sig, 4'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_pass", pass, 1'b0);
        checkOutput("rst_valid", pat_valid, 1'b0);
        rst = 1'b0;

        // Zero-response run: pattern sequence, run length and uniqueness.
        for (int i = 0; i < 32; i++) seen[i] = 1'b0;
        nbusy = 0; nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].start, 1'b0);
            checkOutput($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            checkOutput($sformatf("tbl%0d_done", i), done, tbl[i].done);
            checkOutput($sformatf("tbl%0d_pat", i), pat, tbl[i].pat);
            checkOutput($sformatf("tbl%0d_sig", i), sig, tbl[i].sig);
            if (busy) begin nbusy++; seen[pat] = 1'b1; end
            if (pat_valid) nvalid++;
        end
        for (int g = 0; g < 100 && busy; g++) begin
            applyStimulus(1'b0, 1'b0);
            if (busy) begin nbusy++; seen[pat] = 1'b1; end
            if (pat_valid) nvalid++;
        end
        ndistinct = 0;
        for (int i = 1; i < 32; i++) if (seen[i]) ndistinct++;
        checkOutput("zero_busy_cycles", nbusy, 31);
        checkOutput("zero_valid_cycles", nvalid, 31);
        checkOutput("zero_distinct_pats", ndistinct, 31);
        checkOutput("zero_pat0_unused", seen[0], 1'b0);
        checkOutput("zero_done", done, 1'b1);
        checkOutput("zero_pass", pass, 1'b1);
        checkOutput("zero_sig", sig, 4'h0);
        checkOutput("zero_pat_wrap", pat, 5'h01);
        applyStimulus(1'b0, 1'b0);
        checkOutput("done_holds", done, 1'b1);

        // Fault-free vs stuck-at fault.
        rsp_mode = 1; fault = 1'b0;
        golden = model_sig(NUM_PAT);
        exp_sig = golden;
        applyRun(1'b0);
        checkOutput("good_pass", pass, 1'b1);
        checkOutput("good_sig", sig, golden);
        fault = 1'b1;
        faulty = model_sig(NUM_PAT);
        applyRun(1'b0);
        checkOutput("fault_pass", pass, 1'b0);
        checkOutput("fault_sig", sig, faulty);
        checkOutput("fault_sig_differs", sig != golden, 1'b1);
        fault = 1'b0;

        // Abort at RUN cycle 10, then restart.
        applyStimulus(1'b1, 1'b0);
        repeat (9) applyStimulus(1'b0, 1'b0);
        checkOutput("abort_pre_pat", pat, model_pat(9));
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_pass", pass, 1'b0);
        checkOutput("abort_pat_hold", pat, model_pat(9));
        checkOutput("abort_sig_hold", sig, model_sig(9));
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart_busy", busy, 1'b1);
        checkOutput("restart_pat", pat, 5'h01);
        checkOutput("restart_sig", sig, 4'h0);

        // Asynchronous reset mid-run.
        repeat (5) applyStimulus(1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_pat", pat, 5'h01);
        checkOutput("arst_sig", sig, 4'h0);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_done", done, 1'b0);
        rst = 1'b0;

        // Start held high through DONE re-runs immediately with pass cleared.
        exp_sig = golden;
        applyRun(1'b1);
        checkOutput("held_done", done, 1'b1);
        checkOutput("held_pass", pass, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("held_rerun_busy", busy, 1'b1);
        checkOutput("held_rerun_pass", pass, 1'b0);
        checkOutput("held_rerun_pat", pat, 5'h01);
        applyStimulus(1'b1, 1'b0);
        checkOutput("held_rerun_pass2", pass, 1'b0);
        applyStimulus(1'b0, 1'b1);

        // Randomised responses, golden values and abort points vs the model.
        rsp_mode = 2;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 32; i++) lut[i] = 4'($urandom);
            golden = model_sig(NUM_PAT);
            exp_sig = ($urandom_range(1) == 1) ? golden : 4'($urandom);
            exp_pass = {3'b000, golden == exp_sig};
            abort_at = ($urandom_range(2) == 0) ? int'($urandom_range(30)) : -1;
            applyStimulus(1'b1, 1'b0);
            q = SEED;
            for (int k = 0; k < NUM_PAT; k++) begin
                checkOutput($sformatf("rnd%0d_pat%0d", it, k), pat, q);
                checkOutput($sformatf("rnd%0d_sig%0d", it, k), sig, model_sig(k));
                checkOutput($sformatf("rnd%0d_busy%0d", it, k), busy, 1'b1);
                if (k == abort_at) begin
                    applyStimulus(1'b0, 1'b1);
                    checkOutput($sformatf("rnd%0d_abort_busy", it), busy, 1'b0);
                    checkOutput($sformatf("rnd%0d_abort_pat", it), pat, q);
                    checkOutput($sformatf("rnd%0d_abort_sig", it), sig, model_sig(k));
                    break;
                end
                applyStimulus(1'b0, 1'b0);
                q = m_lfsr(q);
            end
            if (abort_at < 0) begin
                checkOutput($sformatf("rnd%0d_done", it), done, 1'b1);
                checkOutput($sformatf("rnd%0d_final_sig", it), sig, golden);
                checkOutput($sformatf("rnd%0d_pass", it), pass, exp_pass[0]);
            end
        end

        // Single-pattern instance.
        rsp2 = 4'hF; exp2 = 4'hF;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        checkOutput("np1_busy", busy2, 1'b1);
        checkOutput("np1_pat", pat2, 5'h01);
        tick();
        checkOutput("np1_done", done2, 1'b1);
        checkOutput("np1_sig", sig2, 4'hF);
        checkOutput("np1_pass", pass2, 1'b1);
        exp2 = 4'hE;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        checkOutput("np1b_busy", busy2, 1'b1);
        checkOutput("np1b_pass_cleared", pass2, 1'b0);
        tick();
        checkOutput("np1b_done", done2, 1'b1);
        checkOutput("np1b_sig", sig2, 4'hF);
        checkOutput("np1b_pass", pass2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
